// File: rtl/button_prob.sv
// rtl/button_prob.sv - synchronised, debounced push-button single-pulse generator
//
// Purpose:
//   Conditions a raw, bouncing, asynchronous push-button level. The block
//   synchronises the button, debounces it with a stability counter, and
//   produces one registered single-cycle pulse for each accepted press.
//
// Ports:
//   clock   : system clock; all state updates on the rising edge
//   reset_n : asynchronous active-low reset; clears all state
//   button  : raw active-high button level, asynchronous, may bounce
//   btn_opt : registered single-cycle press pulse, active-high
`timescale 1us/1ns
module button_prob #(
  parameter int unsigned STABLE_CYCLES = 3
) (
  input  logic clock,
  input  logic reset_n,
  input  logic button,
  output logic btn_opt
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  // With a single required sample the entry sample already satisfies
  // acceptance, so both wait states are skipped.
  localparam bit ONE_SAMPLE = (STABLE_CYCLES == 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               sync1_q, sync2_q;
  logic               pulse_q, pulse_d;
  logic               s;
  logic               accept;

  // Only the synchroniser reads the raw button.
  assign s = sync2_q;

  // The current sample completes the required run when cnt+1 reaches the
  // target; evaluated in 32 bits so the compare never wraps.
  assign accept = ((32'(cnt_q) + 32'd1) == 32'(STABLE_CYCLES));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          if (ONE_SAMPLE) begin
            state_d = PRESSED;
            cnt_d   = '0;
            pulse_d = 1'b1;
          end else begin
            state_d = PRESS_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          // Bounce: drop back without pulsing.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (accept) begin
          state_d = PRESSED;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (!s) begin
          if (ONE_SAMPLE) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = RELEASE_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          // Release bounce: still held, so no new press is recognised.
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (accept) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign btn_opt = pulse_q;

endmodule

// File: tb/tb_button_prob.sv
// tb/tb_button_prob.sv - self-checking bench for button_prob (STABLE_CYCLES 3 and 1)
`timescale 1us/1ns
module tb_button_prob;

  logic clock;
  logic reset_n;
  logic button;
  logic opt3;
  logic opt1;

  int n_checks = 0;
  int n_fail   = 0;

  button_prob #(.STABLE_CYCLES(3)) dut3 (
    .clock   (clock),
    .reset_n (reset_n),
    .button  (button),
    .btn_opt (opt3)
  );

  button_prob #(.STABLE_CYCLES(1)) dut1 (
    .clock   (clock),
    .reset_n (reset_n),
    .button  (button),
    .btn_opt (opt1)
  );

  // 2 ms period: rising edges at odd milliseconds, falling at even.
  initial clock = 1'b0;
  always #1000 clock = ~clock;

  task automatic check(input string tag, input int observed, input int expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", tag, observed, expected, $time);
    end
  endtask

  // Reference model: the button reaches the decision logic two edges late;
  // the accepted level flips once the last N samples all disagree with it,
  // and a pulse appears whenever the accepted level becomes 1.
  int edge_cnt = 0;
  bit s1m, s2m;
  bit hist[$];
  bit acc3, acc1;
  bit exp3, exp1;

  function automatic bit run_of(input bit q[$], input int n, input bit v);
    if (q.size() < n) return 1'b0;
    for (int i = q.size() - n; i < q.size(); i++)
      if (q[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clock) edge_cnt++;

  always @(posedge clock or negedge reset_n) begin
    bit s;
    if (!reset_n) begin
      s1m = 1'b0; s2m = 1'b0;
      hist.delete();
      acc3 = 1'b0; acc1 = 1'b0;
      exp3 = 1'b0; exp1 = 1'b0;
    end else begin
      s   = s2m;
      s2m = s1m;
      s1m = button;
      hist.push_back(s);
      if (hist.size() > 8) void'(hist.pop_front());
      exp3 = 1'b0;
      if (run_of(hist, 3, !acc3)) begin
        acc3 = !acc3;
        exp3 = acc3;
      end
      exp1 = 1'b0;
      if (run_of(hist, 1, !acc1)) begin
        acc1 = !acc1;
        exp1 = acc1;
      end
    end
  end

  // Cycle-by-cycle comparison plus pulse bookkeeping for directed checks.
  int pc3 = 0, pc1 = 0;
  int fe3 = -1, fe1 = -1;

  always @(negedge clock) begin
    check("pulse_n3", int'(opt3), int'(exp3));
    check("pulse_n1", int'(opt1), int'(exp1));
    if (opt3) begin
      pc3++;
      if (fe3 < 0) fe3 = edge_cnt;
    end
    if (opt1) begin
      pc1++;
      if (fe1 < 0) fe1 = edge_cnt;
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clock);
    #10;
  endtask

  int k, b3, b1;

  task automatic mark();
    k  = edge_cnt;
    b3 = pc3;
    b1 = pc1;
    fe3 = -1;
    fe1 = -1;
  endtask

  initial begin
    button  = 1'b1;
    reset_n = 1'b0;

    // Reset held with the button high: outputs stay low.
    wait_cyc(3);
    check("rst_held_n3", int'(opt3), 0);
    check("rst_held_n1", int'(opt1), 0);
    #90 reset_n = 1'b1;
    mark();
    wait_cyc(10);
    check("rst_cnt_n3", pc3 - b3, 1);
    check("rst_cnt_n1", pc1 - b1, 1);
    check("rst_lat_n3", fe3, k + 1 + 4);
    check("rst_lat_n1", fe1, k + 1 + 2);
    button = 1'b0;
    wait_cyc(10);

    // Three clean presses at 13.8-23.3, 32.0-46.5, 52.0-62.0 ms.
    b3 = pc3; b1 = pc1;
    #13790 button = 1'b1;
    mark();
    #9500  button = 1'b0;
    #8700;
    check("clean_cnt_n3", pc3 - b3, 1);
    check("clean_lat_n3", fe3, k + 1 + 4);
    check("clean_lat_n1", fe1, k + 1 + 2);
    button = 1'b1;
    #14500 button = 1'b0;
    #5500  button = 1'b1;
    #10000 button = 1'b0;
    #20000;
    check("seq_cnt_n3", pc3 - b3, 3);
    check("seq_cnt_n1", pc1 - b1, 3);

    // Press bounce 1,0,1,0 then hold: one pulse timed from the final rise.
    wait_cyc(1);
    mark();
    button = 1'b1; wait_cyc(1);
    button = 1'b0; wait_cyc(1);
    button = 1'b1; wait_cyc(1);
    button = 1'b0; wait_cyc(1);
    button = 1'b1;
    k = edge_cnt;
    wait_cyc(12);
    check("bounce_cnt_n3", pc3 - b3, 1);
    check("bounce_lat_n3", fe3, k + 1 + 4);

    // Release bounce while pressed: no pulse.
    b3 = pc3;
    button = 1'b0; wait_cyc(1);
    button = 1'b1; wait_cyc(10);
    check("relbounce_cnt_n3", pc3 - b3, 0);
    button = 1'b0; wait_cyc(6);
    b3 = pc3;
    button = 1'b1; wait_cyc(10);
    check("repress_cnt_n3", pc3 - b3, 1);
    button = 1'b0; wait_cyc(8);

    // Long hold of 100 cycles.
    b3 = pc3; b1 = pc1;
    button = 1'b1; wait_cyc(100);
    button = 1'b0; wait_cyc(10);
    check("hold_cnt_n3", pc3 - b3, 1);
    check("hold_cnt_n1", pc1 - b1, 1);

    // Reset in mid-debounce with the button still high: fresh full latency.
    b3 = pc3;
    button = 1'b1; wait_cyc(3);
    #300 reset_n = 1'b0;
    check("midrst_none_n3", pc3 - b3, 0);
    wait_cyc(2);
    check("midrst_held_n3", int'(opt3), 0);
    reset_n = 1'b1;
    mark();
    wait_cyc(10);
    check("midrst_cnt_n3", pc3 - b3, 1);
    check("midrst_lat_n3", fe3, k + 1 + 4);
    button = 1'b0; wait_cyc(8);

    // Random bouncy activity, compared cycle by cycle against the model.
    for (int i = 0; i < 400; i++) begin
      button = 1'($urandom_range(0, 1));
      wait_cyc($urandom_range(1, 5));
      #($urandom_range(0, 800));
    end
    button = 1'b0;
    wait_cyc(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/button_prob.md
Name: button_prob

Overview:
- Push-button conditioner between a raw, bouncing, asynchronous button pin and synchronous control logic.
- Synchronises the button, debounces it with a stability counter, and emits exactly one single-cycle pulse per accepted press.
- Bounces, glitches and held buttons never produce extra pulses.
- Sits at the board-input boundary in front of any press-driven counter or FSM.

Parameters:
- STABLE_CYCLES, 3: consecutive clock samples of a constant synchronised level needed to accept a press or a release. Legal range 1..65535.
- CNT_W, $clog2(STABLE_CYCLES+1): width of the stability counter. Derived; must not be overridden.

Ports:
- clock, input, 1: single system clock; all state on the rising edge. The nominal bench clock is a 2 ms period, but the design is period-agnostic.
- reset_n, input, 1: asynchronous active-low reset. Assertion clears all state immediately. Deassertion is synchronised externally.
- button, input, 1: raw button level, active-high, asynchronous to clock and may bounce.
- btn_opt, output, 1: registered single-cycle press pulse, active-high.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - sync1, sync2, state, counter and btn_opt all go to 0; state = IDLE.
  - btn_opt stays 0 while reset is held.
- Synchroniser: two-flop chain, button->sync1->sync2. Signal s = sync2. No other logic may read button.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - IDLE: if s=1, go to PRESS_WAIT with cnt=1; otherwise stay.
  - PRESS_WAIT:
    - s=0: return to IDLE, cnt=0. This is a bounce; no pulse.
    - s=1 and cnt+1 < STABLE_CYCLES: cnt increments.
    - s=1 and cnt+1 == STABLE_CYCLES: go to PRESSED, cnt=0, btn_opt=1 for this one cycle.
  - STABLE_CYCLES=1: the IDLE->PRESS_WAIT sample itself satisfies acceptance, so IDLE goes straight to PRESSED with the pulse.
  - PRESSED: btn_opt=0. If s=0, go to RELEASE_WAIT with cnt=1; if s=1, stay with no further pulses, however long the button is held.
  - RELEASE_WAIT:
    - s=1: return to PRESSED, cnt=0. This is a release bounce; no pulse.
    - s=0 for STABLE_CYCLES consecutive samples in total: go to IDLE, cnt=0.
- btn_opt:
  - Registered; high only in the cycle immediately after the accepting edge.
  - Never high in two consecutive cycles.
  - Exactly one pulse per IDLE->...->PRESSED traversal.
- Latency: button rises and stays high, first sampled by sync1 at edge E0. s=1 is first seen by the FSM at edge E2. btn_opt is high during the cycle following edge E0+STABLE_CYCLES+1. Default: pulse after edge E4, 4 edges after E0.
- A press is acknowledged only after a full debounced release back to IDLE. A new rising level while in RELEASE_WAIT returns to PRESSED without pulsing.
- Counter saturates by design. cnt never exceeds STABLE_CYCLES-1 and never wraps.
- Reset mid-press (any state): immediate return to IDLE with btn_opt=0. If button is still high after deassertion, it is treated as a fresh press: a full sync plus debounce latency, then one pulse.
- Glitch shorter than STABLE_CYCLES samples at s: no pulse, and the FSM returns to its prior stable state (IDLE or PRESSED).
- No combinational path from button to btn_opt.

Test Plan:
- Reset: reset_n=0 for 3 cycles with button=1 -> btn_opt=0 throughout. Release reset with button held -> exactly one pulse, 4 edges after the first post-reset sampling edge (STABLE_CYCLES=3).
- Clean press, default parameters, 2 ms clock: button 0->1 at 13.8 ms, held until 23.3 ms -> exactly one 1-cycle pulse ~8 ms after the rise, then btn_opt=0 for the rest of the hold.
- Sequence of presses: button high 13.8–23.3 ms, 32.0–46.5 ms and 52.0–62.0 ms, low in between -> exactly 3 pulses, one per press; none on any release.
- Bounce on press: button toggles 1,0,1,0 with each level lasting 1 clock, then holds 1 -> single pulse, timed from the final stable rise.
- Bounce on release: while PRESSED, drop for 1 cycle then return high -> no pulse. Then a clean release of ≥5 cycles followed by a new press -> one pulse.
- Long hold: button high for 100 cycles -> exactly one pulse. Also check with STABLE_CYCLES=1: pulse 2 edges after E0 and one pulse per press.
